// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional feature macro: SRAM_ARB_INIT_EN (power-on zero fill of the SRAM).
package sram_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int PKG_ADR_W  = 8;
  localparam int PKG_DATA_W = 32;
  localparam int STRB_W     = PKG_DATA_W / 8;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic                  wen;
    logic [PKG_ADR_W-1:0]  adr;
    logic [STRB_W-1:0]     wstrb;
    logic [PKG_DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_arb_rsp_fifo.sv
// Per-port response ring buffer. Space is reserved upstream by credits, so a
// push while full is only legal together with a pop.
module sram_arb_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign valid = (count != '0);
  assign pop   = ready && valid;
  assign data  = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data-only and needs no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/sram_arb2.sv
// Two-port round-robin arbiter/sequencer in front of a single-port sync SRAM.
// Optional feature macro: SRAM_ARB_INIT_EN -- zero-fills the whole SRAM after
// reset before accepting any request.
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter int ADR_W     = 8,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic                p0_req_wen,
  input  logic [ADR_W-1:0]    p0_req_adr,
  input  logic [DATA_W/8-1:0] p0_req_wstrb,
  input  logic [DATA_W-1:0]   p0_req_wdata,
  output logic                p0_rsp_valid,
  input  logic                p0_rsp_ready,
  output logic [DATA_W-1:0]   p0_rsp_rdata,
  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic                p1_req_wen,
  input  logic [ADR_W-1:0]    p1_req_adr,
  input  logic [DATA_W/8-1:0] p1_req_wstrb,
  input  logic [DATA_W-1:0]   p1_req_wdata,
  output logic                p1_rsp_valid,
  input  logic                p1_rsp_ready,
  output logic [DATA_W-1:0]   p1_rsp_rdata,
  output logic [ADR_W-1:0]    io_adr,
  output logic                io_cen,
  output logic                io_wen,
  output logic [DATA_W/8-1:0] io_wstrb,
  output logic [DATA_W-1:0]   io_d,
  input  logic [DATA_W-1:0]   io_q
);

  localparam int WSTRB_W = DATA_W / 8;
  localparam int CW      = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

  logic                 run;
  logic                 init_active;
  logic [ADR_W-1:0]     init_adr;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant;
  logic [1:0]           inf0, inf1;
  logic [CW:0]          use0, use1;
  logic [CW-1:0]        cnt0, cnt1;
  port_id_t             last_grant;
  logic                 vld_p1, vld_p2;
  port_id_t             pid_p1, pid_p2;
  logic                 wen_p2;
  logic                 sel_wen;
  logic [ADR_W-1:0]     sel_adr;
  logic [WSTRB_W-1:0]   sel_wstrb;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 push0, push1;
  logic [DATA_W-1:0]    push_data;

`ifdef SRAM_ARB_INIT_EN
  state_t state, state_nx;

  // FSM state register: INIT after every reset.
  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_nx;
  end

  // Fill address walks the whole SRAM once while in INIT.
  always_ff @(posedge clock) begin
    if (reset)              init_adr <= '0;
    else if (state == INIT) init_adr <= init_adr + 1'b1;
  end

  // Next state: leave INIT after the last address has been issued.
  always_comb begin
    state_nx = state;
    if ((state == INIT) && (init_adr == '1)) state_nx = RUN;
  end

  // FSM outputs: requests are only served in RUN.
  always_comb begin
    run         = (state == RUN);
    init_active = (state == INIT);
  end
`else
  assign run         = 1'b1;
  assign init_active = 1'b0;
  assign init_adr    = '0;
`endif

  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];

  // Eligibility needs a reserved FIFO slot for every command still in the pipe.
  always_comb begin
    inf0 = {1'b0, vld_p1 && (pid_p1 == 1'b0)} + {1'b0, vld_p2 && (pid_p2 == 1'b0)};
    inf1 = {1'b0, vld_p1 && (pid_p1 == 1'b1)} + {1'b0, vld_p2 && (pid_p2 == 1'b1)};
    use0 = {1'b0, cnt0} + {{(CW-1){1'b0}}, inf0};
    use1 = {1'b0, cnt1} + {{(CW-1){1'b0}}, inf1};
    elig[0] = p0_req_valid && (use0 < DEPTH_L);
    elig[1] = p1_req_valid && (use1 < DEPTH_L);
    grant = '0;
    if (run && !reset) begin
      if (elig[0] && (!elig[1] || (last_grant == 1'b1))) grant[0] = 1'b1;
      else if (elig[1])                                  grant[1] = 1'b1;
    end
  end

  // Payload of the winning port.
  always_comb begin
    sel_wen   = grant[1] ? p1_req_wen   : p0_req_wen;
    sel_adr   = grant[1] ? p1_req_adr   : p0_req_adr;
    sel_wstrb = grant[1] ? p1_req_wstrb : p0_req_wstrb;
    sel_wdata = grant[1] ? p1_req_wdata : p0_req_wdata;
  end

  // Stage p1: registered SRAM command; address/data hold when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_cen   <= 1'b0;
      io_wen   <= 1'b0;
      io_adr   <= '0;
      io_wstrb <= '0;
      io_d     <= '0;
    end else if (init_active) begin
      io_cen   <= 1'b1;
      io_wen   <= 1'b1;
      io_adr   <= init_adr;
      io_wstrb <= '1;
      io_d     <= '0;
    end else if (grant != '0) begin
      io_cen   <= 1'b1;
      io_wen   <= sel_wen;
      io_adr   <= sel_adr;
      io_wstrb <= sel_wen ? sel_wstrb : '0;
      io_d     <= sel_wdata;
    end else begin
      io_cen <= 1'b0;
      io_wen <= 1'b0;
    end
  end

  // Valid pipeline and round-robin pointer; reset drops in-flight commands.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      vld_p1 <= (grant != '0);
      vld_p2 <= vld_p1;
      if (grant != '0) last_grant <= grant[1];
    end
  end

  // Port-id and op tags travel beside the valid bits.
  always_ff @(posedge clock) begin
    pid_p1 <= grant[1];
    pid_p2 <= pid_p1;
    wen_p2 <= io_wen;
  end

  // Stage p2: io_q is valid now; write acks return zero.
  assign push_data = wen_p2 ? '0 : io_q;
  assign push0     = vld_p2 && (pid_p2 == 1'b0);
  assign push1     = vld_p2 && (pid_p2 == 1'b1);

  sram_arb_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_W), .CNT_W(CW)) u_fifo0 (
    .clock(clock), .reset(reset), .push(push0), .push_data(push_data),
    .ready(p0_rsp_ready), .valid(p0_rsp_valid), .data(p0_rsp_rdata), .count(cnt0)
  );

  sram_arb_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_W), .CNT_W(CW)) u_fifo1 (
    .clock(clock), .reset(reset), .push(push1), .push_data(push_data),
    .ready(p1_rsp_ready), .valid(p1_rsp_valid), .data(p1_rsp_rdata), .count(cnt1)
  );

endmodule

// File: tb/tb_sram_arb2.sv
// Bench for sram_arb2 with a behavioural 256x32 byte-strobed SRAM.
// Optional feature macro: SRAM_ARB_INIT_EN (zero-fill after reset).
module tb_sram_arb2;
  import sram_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_ready, p0_req_wen;
  logic [7:0]  p0_req_adr;
  logic [3:0]  p0_req_wstrb;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_ready;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_wen;
  logic [7:0]  p1_req_adr;
  logic [3:0]  p1_req_wstrb;
  logic [31:0] p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_ready;
  logic [31:0] p1_rsp_rdata;
  logic [7:0]  io_adr;
  logic        io_cen, io_wen;
  logic [3:0]  io_wstrb;
  logic [31:0] io_d;
  logic [31:0] io_q;

  always #5 clock = ~clock;

  sram_arb2 #(.ADR_W(8), .DATA_W(32), .RSP_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wen(p0_req_wen),
    .p0_req_adr(p0_req_adr), .p0_req_wstrb(p0_req_wstrb), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wen(p1_req_wen),
    .p1_req_adr(p1_req_adr), .p1_req_wstrb(p1_req_wstrb), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .io_adr(io_adr), .io_cen(io_cen), .io_wen(io_wen), .io_wstrb(io_wstrb),
    .io_d(io_d), .io_q(io_q)
  );

  // Behavioural single-port SRAM: read data appears the cycle after io_cen.
  logic [31:0] sram [256];
  always @(posedge clock) begin
    if (io_cen) begin
      if (io_wen) begin
        for (int b = 0; b < 4; b++)
          if (io_wstrb[b]) sram[io_adr][8*b +: 8] <= io_d[8*b +: 8];
      end else begin
        io_q <= sram[io_adr];
      end
    end
  end

  typedef struct packed {
    logic        port;
    cmd_t        cmd;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          pops0 = 0;
  int          pops1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic port, input logic wen, input logic [7:0] adr,
                              input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.port = port; v.cmd.wen = wen; v.cmd.adr = adr; v.cmd.wstrb = s;
    v.cmd.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic port, input logic v, input cmd_t c);
    if (port == 1'b0) begin
      p0_req_valid = v; p0_req_wen = c.wen; p0_req_adr = c.adr;
      p0_req_wstrb = c.wstrb; p0_req_wdata = c.wdata;
    end else begin
      p1_req_valid = v; p1_req_wen = c.wen; p1_req_adr = c.adr;
      p1_req_wstrb = c.wstrb; p1_req_wdata = c.wdata;
    end
  endtask

  function automatic logic rdy(input logic port);
    return port ? p1_req_ready : p0_req_ready;
  endfunction

  function automatic logic rsp_v(input logic port);
    return port ? p1_rsp_valid : p0_rsp_valid;
  endfunction

  function automatic logic [31:0] rsp_d(input logic port);
    return port ? p1_rsp_rdata : p0_rsp_rdata;
  endfunction

  // Scoreboard: expectations are pushed at request handshake, popped at response.
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q0.delete();
        exp_q1.delete();
`ifdef SRAM_ARB_INIT_EN
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
`endif
      end else begin
        if (p0_rsp_valid && p0_rsp_ready) begin
          pops0++;
          if (exp_q0.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL p0_rsp_unexpected: got 0x%08h, expected no response", p0_rsp_rdata);
          end else chk("p0_rsp_order", p0_rsp_rdata, exp_q0.pop_front());
        end
        if (p1_rsp_valid && p1_rsp_ready) begin
          pops1++;
          if (exp_q1.size() == 0) begin
            vec_cnt++; err_cnt++;
            $display("FAIL p1_rsp_unexpected: got 0x%08h, expected no response", p1_rsp_rdata);
          end else chk("p1_rsp_order", p1_rsp_rdata, exp_q1.pop_front());
        end
        if (p0_req_valid && p0_req_ready) begin
          if (p0_req_wen) begin
            ref_mem[p0_req_adr] = merge(ref_mem[p0_req_adr], p0_req_wdata, p0_req_wstrb);
            exp_q0.push_back(32'h0);
          end else exp_q0.push_back(ref_mem[p0_req_adr]);
        end
        if (p1_req_valid && p1_req_ready) begin
          if (p1_req_wen) begin
            ref_mem[p1_req_adr] = merge(ref_mem[p1_req_adr], p1_req_wdata, p1_req_wstrb);
            exp_q1.push_back(32'h0);
          end else exp_q1.push_back(ref_mem[p1_req_adr]);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
`ifdef SRAM_ARB_INIT_EN
    repeat (257) tick();
`endif
  endtask

  // One isolated transaction: command timing, latency and returned data.
  task automatic run_vec(input int i, input vec_t v);
    int  lat;
    logic got;
    drive(v.port, 1'b1, v.cmd);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rdy(v.port)) begin got = 1'b1; break; end
    end
    if (!got) begin
      vec_cnt++; err_cnt++;
      $display("FAIL vec%0d_accept: got no req_ready in 20 cycles, expected a grant", i);
      drive(v.port, 1'b0, v.cmd);
      tick();
      return;
    end
    tick();
    drive(v.port, 1'b0, v.cmd);
    chk($sformatf("vec%0d_io_cen", i), 32'(io_cen), 32'h1);
    chk($sformatf("vec%0d_io_adr", i), 32'(io_adr), 32'(v.cmd.adr));
    chk($sformatf("vec%0d_io_wen", i), 32'(io_wen), 32'(v.cmd.wen));
    chk($sformatf("vec%0d_io_wstrb", i), 32'(io_wstrb), v.cmd.wen ? 32'(v.cmd.wstrb) : 32'h0);
    if (v.cmd.wen) chk($sformatf("vec%0d_io_d", i), io_d, v.cmd.wdata);
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      lat++;
      if (rsp_v(v.port)) begin got = 1'b1; break; end
    end
    if (!got) begin
      vec_cnt++; err_cnt++;
      $display("FAIL vec%0d_rsp: got no rsp_valid in 10 cycles, expected latency 3", i);
    end else begin
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_rdata", i), rsp_d(v.port), v.exp);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, g0, g1, alt_err, cen_cnt, acc0, bp_err, stale, base;
    logic got;
    logic [7:0] bp_adr [4];
    cmd_t c;

    vecs[0]  = mk(1'b0, 1'b1, 8'h10, 4'hF, 32'hCAFEF00D, 32'h0);
    vecs[1]  = mk(1'b0, 1'b0, 8'h10, 4'hF, 32'h0,        32'hCAFEF00D);
    vecs[2]  = mk(1'b1, 1'b1, 8'h20, 4'hF, 32'hAAAAAAAA, 32'h0);
    vecs[3]  = mk(1'b1, 1'b1, 8'h20, 4'h5, 32'h11223344, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 8'h20, 4'hF, 32'h0,        32'hAA22AA44);
    vecs[5]  = mk(1'b0, 1'b0, 8'h20, 4'hF, 32'h0,        32'hAA22AA44);
    vecs[6]  = mk(1'b0, 1'b1, 8'hFF, 4'hF, 32'h12345678, 32'h0);
    vecs[7]  = mk(1'b1, 1'b1, 8'hFF, 4'h8, 32'hAB000000, 32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 8'hFF, 4'h0, 32'h0,        32'hAB345678);
    vecs[9]  = mk(1'b0, 1'b1, 8'h00, 4'hF, 32'h55555555, 32'h0);
    vecs[10] = mk(1'b0, 1'b1, 8'h00, 4'h0, 32'hFFFFFFFF, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 8'h00, 4'hF, 32'h0,        32'h55555555);
    bp_adr[0] = 8'h10; bp_adr[1] = 8'h20; bp_adr[2] = 8'hFF; bp_adr[3] = 8'h00;

    c = '0;
    drive(1'b0, 1'b0, c);
    drive(1'b1, 1'b0, c);
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    reset = 1'b1;
    fork monitor(); join_none

    // Reset state.
    tick();
    tick();
    @(negedge clock);
    chk("reset_ctrl", 32'({io_cen, io_wen, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid}), 32'h0);
    chk("reset_io_adr", 32'(io_adr), 32'h0);
    chk("reset_io_wstrb", 32'(io_wstrb), 32'h0);
    chk("reset_io_d", io_d, 32'h0);
    chk("reset_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'h0);
    tick();
    reset = 1'b0;

`ifdef SRAM_ARB_INIT_EN
    // Zero fill: no grant for 2^ADR_W cycles, then 0xFF reads back 0.
    c.wen = 1'b0; c.adr = 8'hFF; c.wstrb = 4'h0; c.wdata = '0;
    drive(1'b0, 1'b1, c);
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (p0_req_ready) begin got = 1'b1; break; end
      n++;
      if (n == 100) begin
        chk("init_io_cmd", 32'({io_cen, io_wen, io_wstrb}), 32'h3F);
        chk("init_io_d", io_d, 32'h0);
      end
    end
    chk("init_ready_low_cycles", 32'(n), 32'd256);
    tick();
    drive(1'b0, 1'b0, c);
    base = pops0;
    repeat (5) tick();
    chk("init_read_count", 32'(pops0 - base), 32'd1);
`endif

    // Isolated transactions from the vector table.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Contention: strict alternation starting with port 0.
    do_reset();
    c.wen = 1'b0; c.wstrb = 4'h0; c.wdata = '0;
    c.adr = 8'h10; drive(1'b0, 1'b1, c);
    c.adr = 8'h20; drive(1'b1, 1'b1, c);
    g0 = 0; g1 = 0; alt_err = 0; cen_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if ((p0_req_ready == p1_req_ready) || (p0_req_ready != ((k % 2) == 0))) alt_err++;
      if (p0_req_ready) g0++;
      if (p1_req_ready) g1++;
      if ((k >= 1) && io_cen) cen_cnt++;
      tick();
    end
    drive(1'b0, 1'b0, c);
    drive(1'b1, 1'b0, c);
    chk("contend_alternation_errors", 32'(alt_err), 32'h0);
    chk("contend_p0_grants", 32'(g0), 32'd10);
    chk("contend_p1_grants", 32'(g1), 32'd10);
    chk("contend_io_cen_cycles", 32'(cen_cnt), 32'd19);
    repeat (6) tick();

    // Backpressure on port 0 while port 1 keeps streaming.
    p0_rsp_ready = 1'b0;
    c.adr = bp_adr[0]; drive(1'b0, 1'b1, c);
    c.adr = 8'h10;     drive(1'b1, 1'b1, c);
    acc0 = 0; bp_err = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      got = p0_req_ready;
      if (got) acc0++;
      if ((k >= 10) && !(p1_req_ready && !p0_req_ready)) bp_err++;
      tick();
      if (got) begin c.adr = bp_adr[acc0 % 4]; drive(1'b0, 1'b1, c); end
    end
    drive(1'b0, 1'b0, c);
    drive(1'b1, 1'b0, c);
    chk("bp_p0_accepts", 32'(acc0), 32'd4);
    chk("bp_p1_stream_errors", 32'(bp_err), 32'h0);
    repeat (3) tick();
    base = pops0;
    p0_rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pops0 - base >= 4) break;
    end
    repeat (2) tick();
    chk("bp_drained", 32'(pops0 - base), 32'd4);

    // Reset the cycle after a port-1 read handshake.
    c.adr = 8'h20; drive(1'b1, 1'b1, c);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (p1_req_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      vec_cnt++; err_cnt++;
      $display("FAIL midreset_accept: got no p1_req_ready in 20 cycles, expected a grant");
    end
    tick();
    drive(1'b1, 1'b0, c);
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("midreset_ctrl", 32'({io_cen, io_wen, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid}), 32'h0);
    chk("midreset_io_adr", 32'(io_adr), 32'h0);
    chk("midreset_io_d", io_d, 32'h0);
    chk("midreset_rdata", p1_rsp_rdata, 32'h0);
    tick();
    reset = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (p1_rsp_valid) stale++;
    end
    chk("midreset_stale_rsp", 32'(stale), 32'h0);

    chk("end_q0_outstanding", 32'(exp_q0.size()), 32'h0);
    chk("end_q1_outstanding", 32'(exp_q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
